// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle core sequencer.
package core_pkg;

    localparam int INST_WIDTH = 32;
    localparam int PC_STEP    = 4;

    typedef enum logic [2:0] {
        FETCH, WAIT, DECODE, EXEC, WB, HALT, TRAP
    } state_e;

    typedef enum logic [1:0] {
        TC_NONE     = 2'd0,
        TC_ILLEGAL  = 2'd1,
        TC_MISALIGN = 2'd2,
        TC_TIMEOUT  = 2'd3
    } trap_cause_e;

endpackage

// File: rtl/core_perf_counter.sv
// Free-running cycle and retired-instruction counters; both wrap at 2^CNT_WIDTH.
module core_perf_counter #(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cycle_en_i,
    input  logic                 instret_inc_i,
    output logic [CNT_WIDTH-1:0] cycle_cnt_o,
    output logic [CNT_WIDTH-1:0] instret_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0] instret_q, instret_d;

    always_comb begin
        cycle_d   = cycle_q;
        instret_d = instret_q;
        if (cycle_en_i)    cycle_d   = cycle_q + ONE;
        if (instret_inc_i) instret_d = instret_q + ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_cnt_o   = cycle_q;
    assign instret_cnt_o = instret_q;

endmodule

// File: rtl/multicycle_core_ctrl.sv
// Multi-cycle sequencer: FETCH -> WAIT -> DECODE -> EXEC -> WB, with sticky halt/trap stops.
module multicycle_core_ctrl
    import core_pkg::*;
#(
    parameter int                 XLEN          = 64,
    parameter logic [XLEN-1:0]    RESET_PC      = 64'h8000_0000,
    parameter int                 CNT_WIDTH     = 64,
    parameter int unsigned        FETCH_TIMEOUT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid_o,
    input  logic                  imem_req_ready_i,
    output logic [XLEN-1:0]       imem_req_addr_o,
    input  logic                  imem_rsp_valid_i,
    input  logic [INST_WIDTH-1:0] imem_rsp_data_i,
    output logic [INST_WIDTH-1:0] inst_o,
    input  logic                  dec_is_ebreak_i,
    input  logic                  dec_not_ipl_i,
    input  logic                  exe_redirect_i,
    input  logic [XLEN-1:0]       exe_target_i,
    output logic [XLEN-1:0]       current_pc_o,
    output logic [XLEN-1:0]       next_pc_o,
    output logic                  rf_wen_o,
    output logic                  exec_en_o,
    output logic                  halt_o,
    output logic                  trap_o,
    output logic [1:0]            trap_cause_o,
    output logic [CNT_WIDTH-1:0]  cycle_cnt_o,
    output logic [CNT_WIDTH-1:0]  instret_cnt_o
);

    localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
    localparam bit              TIMEOUT_EN = (FETCH_TIMEOUT != 0);
    localparam logic [31:0]     TO_LAST    = 32'(FETCH_TIMEOUT - 1);

    state_e                  state_q;
    logic [XLEN-1:0]         pc_q, tgt_q, tgt_d;
    logic [INST_WIDTH-1:0]   inst_q;
    logic [31:0]             wait_q;
    logic                    exec_en_q, rf_wen_q, halt_q, trap_q;
    trap_cause_e             cause_q;

    assign tgt_d = exe_redirect_i ? exe_target_i : pc_q + STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            tgt_q     <= '0;
            inst_q    <= '0;
            wait_q    <= '0;
            exec_en_q <= 1'b0;
            rf_wen_q  <= 1'b0;
            halt_q    <= 1'b0;
            trap_q    <= 1'b0;
            cause_q   <= TC_NONE;
        end else begin
            exec_en_q <= 1'b0;
            rf_wen_q  <= 1'b0;
            case (state_q)
                FETCH: if (imem_req_ready_i) begin
                    state_q <= WAIT;
                    wait_q  <= '0;
                end
                WAIT: begin
                    if (imem_rsp_valid_i) begin
                        inst_q  <= imem_rsp_data_i;
                        state_q <= DECODE;
                    end else if (TIMEOUT_EN && wait_q == TO_LAST) begin
                        state_q <= TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= TC_TIMEOUT;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                // Illegal wins over ebreak when the decoder flags both.
                DECODE: begin
                    if (dec_not_ipl_i) begin
                        state_q <= TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= TC_ILLEGAL;
                    end else if (dec_is_ebreak_i) begin
                        state_q <= HALT;
                        halt_q  <= 1'b1;
                    end else begin
                        state_q   <= EXEC;
                        exec_en_q <= 1'b1;
                    end
                end
                EXEC: begin
                    if (tgt_d[1:0] != 2'b00) begin
                        state_q <= TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= TC_MISALIGN;
                    end else begin
                        tgt_q    <= tgt_d;
                        state_q  <= WB;
                        rf_wen_q <= 1'b1;
                    end
                end
                WB: begin
                    pc_q    <= tgt_q;
                    state_q <= FETCH;
                end
                default: ;
            endcase
        end
    end

    core_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_perf (
        .clk           (clk),
        .rst           (rst),
        .cycle_en_i    (!(state_q == HALT || state_q == TRAP)),
        .instret_inc_i (state_q == WB),
        .cycle_cnt_o   (cycle_cnt_o),
        .instret_cnt_o (instret_cnt_o)
    );

    assign imem_req_valid_o = (state_q == FETCH);
    assign imem_req_addr_o  = pc_q;
    assign inst_o           = inst_q;
    assign current_pc_o     = pc_q;
    assign next_pc_o        = (state_q == WB) ? tgt_q : pc_q;
    assign rf_wen_o         = rf_wen_q;
    assign exec_en_o        = exec_en_q;
    assign halt_o           = halt_q;
    assign trap_o           = trap_q;
    assign trap_cause_o     = cause_q;

endmodule

// File: tb/tb_multicycle_core_ctrl.sv
// Randomized bench for multicycle_core_ctrl with a per-instruction reference model.
module tb_multicycle_core_ctrl;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_ready = 0, rsp_valid = 0, dec_ebreak = 0, dec_ill = 0, redirect = 0;
    logic [31:0] rsp_data = 0;
    logic [63:0] target = 0;

    logic        req_valid, rf_wen, exec_en, halt, trap;
    logic [63:0] addr, cur_pc, nxt_pc, cyc, ret;
    logic [31:0] inst;
    logic [1:0]  cause;

    logic        to_req_valid, to_rf_wen, to_exec_en, to_halt, to_trap;
    logic [63:0] to_addr, to_cur_pc, to_nxt_pc, to_cyc, to_ret;
    logic [31:0] to_inst;
    logic [1:0]  to_cause;

    always #5 clk = ~clk;

    multicycle_core_ctrl dut (
        .clk(clk), .rst(rst),
        .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready), .imem_req_addr_o(addr),
        .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data), .inst_o(inst),
        .dec_is_ebreak_i(dec_ebreak), .dec_not_ipl_i(dec_ill),
        .exe_redirect_i(redirect), .exe_target_i(target),
        .current_pc_o(cur_pc), .next_pc_o(nxt_pc), .rf_wen_o(rf_wen), .exec_en_o(exec_en),
        .halt_o(halt), .trap_o(trap), .trap_cause_o(cause),
        .cycle_cnt_o(cyc), .instret_cnt_o(ret)
    );

    multicycle_core_ctrl #(.FETCH_TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst),
        .imem_req_valid_o(to_req_valid), .imem_req_ready_i(req_ready), .imem_req_addr_o(to_addr),
        .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data), .inst_o(to_inst),
        .dec_is_ebreak_i(dec_ebreak), .dec_not_ipl_i(dec_ill),
        .exe_redirect_i(redirect), .exe_target_i(target),
        .current_pc_o(to_cur_pc), .next_pc_o(to_nxt_pc), .rf_wen_o(to_rf_wen), .exec_en_o(to_exec_en),
        .halt_o(to_halt), .trap_o(to_trap), .trap_cause_o(to_cause),
        .cycle_cnt_o(to_cyc), .instret_cnt_o(to_ret)
    );

    int nt = 0, nf = 0;

    // Architectural model: PC, expected counters, and whether the core is still running.
    logic [63:0] m_pc;
    logic [63:0] m_cyc, m_ret;
    bit          m_run;

    task automatic model_reset();
        m_pc = RST_PC; m_cyc = 0; m_ret = 0; m_run = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (m_run) m_cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; req_ready = 0; rsp_valid = 0; dec_ebreak = 0; dec_ill = 0; redirect = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic run_instr(input bit ill, input bit ebr, input bit redir, input logic [63:0] tgt,
                             input int rdy_dly, input int rsp_dly, output bit stopped);
        logic [31:0] w;
        logic [63:0] t;
        stopped = 0;
        dec_ill = ill; dec_ebreak = ebr; redirect = redir; target = tgt;
        w = $urandom;
        for (int i = 0; i < rdy_dly; i++) begin
            req_ready = 0;
            nt++;
            if ({req_valid, addr} !== {1'b1, m_pc}) begin
                nf++; $display("FAIL fetch_hold: got %h want %h", {req_valid, addr}, {1'b1, m_pc});
            end
            tick();
        end
        req_ready = 1;
        nt++;
        if ({req_valid, addr} !== {1'b1, m_pc}) begin
            nf++; $display("FAIL fetch_accept: got %h want %h", {req_valid, addr}, {1'b1, m_pc});
        end
        tick();
        req_ready = 0;
        for (int i = 0; i < rsp_dly; i++) begin
            nt++;
            if ({req_valid, exec_en, rf_wen} !== 3'b000) begin
                nf++; $display("FAIL wait_idle: got %b want 000", {req_valid, exec_en, rf_wen});
            end
            tick();
        end
        rsp_valid = 1; rsp_data = w;
        tick();
        rsp_valid = 0; rsp_data = $urandom;
        nt++;
        if ({inst, exec_en, rf_wen} !== {w, 2'b00}) begin
            nf++; $display("FAIL decode_ir: got %h want %h", {inst, exec_en, rf_wen}, {w, 2'b00});
        end
        tick();
        if (ill || ebr) begin
            m_run = 0; stopped = 1;
            nt++;
            if ({halt, trap, cause} !== (ill ? 4'b0101 : 4'b1000)) begin
                nf++; $display("FAIL decode_stop: got %b want %b", {halt, trap, cause}, (ill ? 4'b0101 : 4'b1000));
            end
            return;
        end
        t = redir ? tgt : m_pc + 64'd4;
        nt++;
        if ({exec_en, rf_wen, cur_pc} !== {2'b10, m_pc}) begin
            nf++; $display("FAIL exec: got %h want %h", {exec_en, rf_wen, cur_pc}, {2'b10, m_pc});
        end
        tick();
        if (t[1:0] != 2'b00) begin
            m_run = 0; stopped = 1;
            nt++;
            if ({halt, trap, cause} !== 4'b0110) begin
                nf++; $display("FAIL misalign_stop: got %b want 0110", {halt, trap, cause});
            end
            return;
        end
        nt++;
        if ({rf_wen, exec_en, nxt_pc, cur_pc} !== {2'b10, t, m_pc}) begin
            nf++; $display("FAIL wb: got %h want %h", {rf_wen, exec_en, nxt_pc, cur_pc}, {2'b10, t, m_pc});
        end
        tick();
        m_pc = t; m_ret++;
        nt++;
        if ({cur_pc, nxt_pc, ret, cyc, req_valid} !== {m_pc, m_pc, m_ret, m_cyc, 1'b1}) begin
            nf++; $display("FAIL retire: got %h want %h", {cur_pc, nxt_pc, ret, cyc, req_valid},
                           {m_pc, m_pc, m_ret, m_cyc, 1'b1});
        end
    endtask

    task automatic check_frozen();
        for (int i = 0; i < 3; i++) begin
            tick();
            nt++;
            if ({cyc, ret, cur_pc, req_valid, exec_en, rf_wen} !== {m_cyc, m_ret, m_pc, 3'b000}) begin
                nf++; $display("FAIL frozen: got %h want %h", {cyc, ret, cur_pc, req_valid, exec_en, rf_wen},
                               {m_cyc, m_ret, m_pc, 3'b000});
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        nt++;
        if ({req_valid, addr, inst, cyc, ret, halt, trap, cause, exec_en, rf_wen} !==
            {1'b1, RST_PC, 32'h0, 64'h0, 64'h0, 6'b000000}) begin
            nf++; $display("FAIL reset_state: got %h", {req_valid, addr, inst, cyc, ret, halt, trap, cause});
        end
        req_ready = 1;
        tick();
        req_ready = 0;
        tick();
        rst = 1;
        #1;
        nt++;
        if ({cur_pc, req_valid, cyc, ret} !== {RST_PC, 1'b1, 64'h0, 64'h0}) begin
            nf++; $display("FAIL reset_mid_wait: got %h want %h", {cur_pc, req_valid, cyc, ret},
                           {RST_PC, 1'b1, 64'h0, 64'h0});
        end
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
        rsp_valid = 1; rsp_data = 32'hDEAD_BEEF;
        tick();
        rsp_valid = 0;
        nt++;
        if ({req_valid, inst, cyc} !== {1'b1, 32'h0, 64'd1}) begin
            nf++; $display("FAIL rsp_outside_wait: got %h want %h", {req_valid, inst, cyc}, {1'b1, 32'h0, 64'd1});
        end
    endtask

    task automatic test_zero_wait();
        bit s;
        do_reset();
        for (int i = 0; i < 10; i++) run_instr(0, 0, 0, 64'h0, 0, 0, s);
        nt++;
        if ({cyc, ret, cur_pc} !== {64'd50, 64'd10, RST_PC + 64'd40}) begin
            nf++; $display("FAIL zero_wait_totals: got %h want %h", {cyc, ret, cur_pc}, {64'd50, 64'd10, RST_PC + 64'd40});
        end
    endtask

    task automatic test_backpressure();
        bit s;
        run_instr(0, 0, 1, 64'h8000_0100, 3, 0, s);
        nt++;
        if (cur_pc !== 64'h8000_0100) begin
            nf++; $display("FAIL jal_target: got %h want 80000100", cur_pc);
        end
        run_instr(0, 0, 0, 64'h0, 1, 2, s);
    endtask

    task automatic test_ebreak();
        bit s;
        do_reset();
        run_instr(0, 0, 0, 64'h0, 0, 0, s);
        run_instr(0, 0, 0, 64'h0, 0, 1, s);
        nt++;
        if (cur_pc !== 64'h8000_0008) begin
            nf++; $display("FAIL ebreak_pc: got %h want 80000008", cur_pc);
        end
        run_instr(0, 1, 0, 64'h0, 0, 0, s);
        check_frozen();
        nt++;
        if ({halt, trap, ret} !== {2'b10, 64'd2}) begin
            nf++; $display("FAIL ebreak_instret: got %h want %h", {halt, trap, ret}, {2'b10, 64'd2});
        end
    endtask

    task automatic test_traps();
        bit s;
        do_reset();
        run_instr(1, 1, 0, 64'h0, 0, 0, s);
        check_frozen();
        do_reset();
        run_instr(0, 0, 0, 64'h0, 0, 0, s);
        run_instr(0, 0, 1, 64'h8000_0102, 0, 0, s);
        check_frozen();
        nt++;
        if ({cause, ret, cur_pc} !== {2'd2, 64'd1, RST_PC + 64'd4}) begin
            nf++; $display("FAIL misalign_totals: got %h want %h", {cause, ret, cur_pc}, {2'd2, 64'd1, RST_PC + 64'd4});
        end
    endtask

    task automatic test_wrap();
        bit s;
        do_reset();
        run_instr(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, s);
        run_instr(0, 0, 0, 64'h0, 0, 0, s);
        nt++;
        if (cur_pc !== 64'h0) begin
            nf++; $display("FAIL pc_wrap: got %h want 0", cur_pc);
        end
    endtask

    task automatic test_random();
        bit s;
        int r;
        logic [63:0] t;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 19);
            t = {$urandom, $urandom} & ~64'h3;
            if (r == 2) t[1:0] = 2'($urandom_range(1, 3));
            run_instr(r == 0, r == 1, (r >= 2 && r < 7), t, $urandom_range(0, 3), $urandom_range(0, 2), s);
            if (s) begin
                check_frozen();
                do_reset();
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req_ready = 1;
        tick();
        req_ready = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            nt++;
            if ({to_trap, to_cause} !== ((k == 4) ? 3'b111 : 3'b000)) begin
                nf++; $display("FAIL timeout_wait%0d: got %b want %b", k, {to_trap, to_cause}, ((k == 4) ? 3'b111 : 3'b000));
            end
        end
        for (int k = 0; k < 20; k++) tick();
        nt++;
        if ({to_cyc, to_req_valid, trap, req_valid, cyc} !== {64'd5, 1'b0, 1'b0, 1'b0, m_cyc}) begin
            nf++; $display("FAIL timeout_freeze: got %h want %h", {to_cyc, to_req_valid, trap, req_valid, cyc},
                           {64'd5, 1'b0, 1'b0, 1'b0, m_cyc});
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_ebreak();
        test_traps();
        test_wrap();
        test_random();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end

endmodule
